uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 18 +
 rtl/uart_rx_fifo_fifo.sv | 82 ++++++++
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receiver with its receive FIFO.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int   DATA_W_DEFAULT = 8;
  localparam logic IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Show-ahead receive FIFO: registered head, occupancy count, push-done pulse
// and a sticky overrun flag that clears on the next accepted pop.
module rx_fifo #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int DATA_W     = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_done,
  output logic              o_overrun
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_head;
  logic              r_done;
  logic              r_overrun;

  logic              w_empty;
  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;
  logic [PTR_W-1:0]  w_rd_next;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign w_rd_next = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_head    <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= w_do_push;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_next;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Head is registered: a fresh write becomes head only when it is the sole entry.
      if (w_do_push && (w_empty || (w_do_pop && r_count == CNT_W'(1))))
        r_head <= i_push_data;
      else if (w_do_pop && r_count > CNT_W'(1))
        r_head <= r_mem[w_rd_next];
      if (i_push && w_full && !i_pop)
        r_overrun <= 1'b1;
      else if (w_do_pop)
        r_overrun <= 1'b0;
    end
  end

  assign o_head    = r_head;
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_count   = r_count;
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding rx_fifo.
// Valid/ready: a byte is offered to the FIFO for exactly one cycle; rd_en pops only when non-empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  parameter  int FIFO_DEPTH   = 16,
  parameter  int DATA_W       = DATA_W_DEFAULT,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_r_in,
  input  logic              rst_n_in,
  input  logic              rx_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] pc_out_r,
  output logic              fifo_rx_empty,
  output logic              fifo_rx_full,
  output logic [CNT_W-1:0]  fifo_rx_count,
  output logic              done,
  output logic              frame_err,
  output logic              overrun,
  output rx_state_t         o_dbg_state
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

  logic              r_rx_meta;
  logic              r_rx_s;
  logic              r_rx_s_d;
  rx_state_t         r_state;
  logic [TICK_W-1:0] r_tick;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_push;
  logic              r_frame_err;
  logic              w_stop_ok;
`ifdef UART_RX_PARITY_EN
  logic              r_par_err;
  assign w_stop_ok = (r_rx_s == IDLE_LEVEL) && !r_par_err;
`else
  assign w_stop_ok = (r_rx_s == IDLE_LEVEL);
`endif

  always_ff @(posedge clk_r_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rx_meta <= IDLE_LEVEL;
      r_rx_s    <= IDLE_LEVEL;
      r_rx_s_d  <= IDLE_LEVEL;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_s    <= r_rx_meta;
      r_rx_s_d  <= r_rx_s;
    end
  end

  always_ff @(posedge clk_r_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tick    <= '0;
          r_bit_idx <= '0;
          if (r_rx_s_d == IDLE_LEVEL && r_rx_s != IDLE_LEVEL) r_state <= START;
        end
        START: begin
          // A start bit that is high again at its midpoint is a glitch.
          if (r_tick == HALF_TICK) begin
            r_tick  <= '0;
            r_state <= (r_rx_s != IDLE_LEVEL) ? DATA : IDLE;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        DATA: begin
          if (r_tick == FULL_TICK) begin
            r_tick    <= '0;
            r_shift   <= {r_rx_s, r_shift[DATA_W-1:1]};
            r_bit_idx <= r_bit_idx + BIT_W'(1);
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_tick == FULL_TICK) begin
            r_tick    <= '0;
            r_par_err <= (^r_shift) ^ r_rx_s;
            r_state   <= STOP;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
`endif
        STOP: begin
          if (r_tick == FULL_TICK) begin
            r_tick      <= '0;
            r_state     <= IDLE;
            r_push      <= w_stop_ok;
            r_frame_err <= !w_stop_ok;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_rx_fifo (
    .i_clk       (clk_r_in),
    .i_rst_n     (rst_n_in),
    .i_push      (r_push),
    .i_push_data (r_shift),
    .i_pop       (rd_en),
    .o_head      (pc_out_r),
    .o_empty     (fifo_rx_empty),
    .o_full      (fifo_rx_full),
    .o_count     (fifo_rx_count),
    .o_done      (done),
    .o_overrun   (overrun)
  );

  assign frame_err   = r_frame_err;
  assign o_dbg_state = r_state;

endmodule
